// File: rtl/stream_fifo.sv
// ----------------------------------------------------------------------------
// stream_fifo
//   Single-clock valid/ready FIFO with first-word fall-through output.
//   It absorbs producer bursts and decouples consumer stalls. It provides a
//   fill level, an almost-full flag and a synchronous flush.
//
// Parameters
//   DATA_W     payload width in bits (>=1)
//   DEPTH      number of entries (power of 2, >=2)
//   AFULL_LVL  afull asserts when level >= AFULL_LVL (1..DEPTH)
//
// Ports
//   clk        clock, rising edge
//   rstb       synchronous active-low reset
//   flush      synchronous clear of contents (reset has priority)
//   inp_valid  producer offers inp_data
//   inp_ready  FIFO accepts a word this cycle (registered)
//   inp_data   producer payload
//   out_valid  head word available (registered)
//   out_ready  consumer takes the head word
//   out_data   head payload, forced to 0 while out_valid=0
//   level      number of stored entries
//   afull      level >= AFULL_LVL
// ----------------------------------------------------------------------------
module stream_fifo #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       flush,
    input  logic                       inp_valid,
    output logic                       inp_ready,
    input  logic [DATA_W-1:0]          inp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       afull
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     level_next;
    logic              wr;
    logic              rd;

    // Handshakes use only the registered ready/valid flags. A full FIFO
    // therefore never writes, even when a read happens in the same cycle.
    assign wr = inp_valid & inp_ready;
    assign rd = out_valid & out_ready;

    always_comb begin
        level_next = level;
        if (wr && !rd)
            level_next = level + LW'(1);
        else if (!wr && rd)
            level_next = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            inp_ready <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Flush overrides any handshake in the same cycle, so that word is dropped.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            inp_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PW'(1);
            if (rd) rd_ptr <= rd_ptr + PW'(1);
            level     <= level_next;
            inp_ready <= (level_next != FULL_L);
            out_valid <= (level_next != '0);
        end
    end

    // Storage is not reset. Writes are suppressed under reset and flush, so
    // stale words never become visible.
    always_ff @(posedge clk) begin
        if (rstb && !flush && wr)
            mem[wr_ptr] <= inp_data;
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign afull    = (level >= AFULL_L);

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rstb;
    logic       flush;
    logic       inp_valid;
    logic       inp_ready;
    logic [3:0] inp_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] level;
    logic       afull;

    int n_chk  = 0;
    int n_pass = 0;

    stream_fifo #(.DATA_W(4), .DEPTH(8), .AFULL_LVL(6)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .flush    (flush),
        .inp_valid(inp_valid),
        .inp_ready(inp_ready),
        .inp_data (inp_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level),
        .afull    (afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] wd;
        logic [3:0] rdv;

        rstb = 1'b0; flush = 1'b0; inp_valid = 1'b0; inp_data = '0; out_ready = 1'b0;

        // 1: reset and idle
        step(); step();
        chk("rst_level", level, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_iready", inp_ready, 0);
        chk("rst_afull", afull, 0);
        rstb = 1'b1;
        step();
        chk("post_rst_iready", inp_ready, 1);
        chk("post_rst_ovalid", out_valid, 0);

        // 2: three writes, then read back in order
        inp_valid = 1'b1;
        inp_data = 4'h3; step();
        inp_data = 4'h5; step();
        inp_data = 4'h9; step();
        inp_valid = 1'b0;
        chk("t2_level", level, 3);
        chk("t2_ovalid", out_valid, 1);
        chk("t2_head", out_data, 4'h3);
        out_ready = 1'b1;
        step(); chk("t2_rd1", out_data, 4'h5);
        step(); chk("t2_rd2", out_data, 4'h9);
        step();
        out_ready = 1'b0;
        chk("t2_empty_ovalid", out_valid, 0);
        chk("t2_empty_level", level, 0);

        // 3: fill, afull, full backpressure, held word accepted after one read
        inp_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inp_data = 4'(i);
            step();
            if (i == 5) chk("t3_afull_l5", afull, 0);
            if (i == 6) chk("t3_afull_l6", afull, 1);
            if (i == 7) chk("t3_iready_l7", inp_ready, 1);
        end
        chk("t3_level_full", level, 8);
        chk("t3_iready_full", inp_ready, 0);
        inp_data = 4'hA;
        step();
        chk("t3_level_held", level, 8);
        chk("t3_head", out_data, 4'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_level_after_rd", level, 7);
        chk("t3_iready_after_rd", inp_ready, 1);
        step();
        inp_valid = 1'b0;
        chk("t3_level_refull", level, 8);
        out_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("t3_drain", out_data, 32'(i));
            step();
        end
        chk("t3_drain_A", out_data, 4'hA);
        step();
        out_ready = 1'b0;
        chk("t3_drained", out_valid, 0);

        // 4: streaming with constant occupancy of 3, pointers wrap
        wd = 4'h0; rdv = 4'h0;
        inp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inp_data = wd; wd = wd + 4'h1; step();
        end
        out_ready = 1'b1;
        inp_data = wd; wd = wd + 4'h1;
        for (int i = 0; i < 20; i++) begin
            chk("t4_level", level, 3);
            chk("t4_data", out_data, rdv);
            rdv = rdv + 4'h1;
            step();
            inp_data = wd; wd = wd + 4'h1;
        end
        inp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_tail", out_data, rdv);
            rdv = rdv + 4'h1;
            step();
        end
        out_ready = 1'b0;
        chk("t4_empty", out_valid, 0);

        // 5: flush with a simultaneous write drops everything
        inp_valid = 1'b1;
        for (int i = 4; i < 8; i++) begin
            inp_data = 4'(i); step();
        end
        chk("t5_level4", level, 4);
        inp_data = 4'hF; flush = 1'b1;
        step();
        flush = 1'b0; inp_valid = 1'b0;
        chk("t5_flush_level", level, 0);
        chk("t5_flush_ovalid", out_valid, 0);
        chk("t5_flush_odata", out_data, 0);
        chk("t5_flush_iready", inp_ready, 1);
        inp_valid = 1'b1; inp_data = 4'h1;
        step();
        inp_valid = 1'b0;
        chk("t5_first_after_flush", out_data, 4'h1);
        chk("t5_level1", level, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_no_F", out_valid, 0);

        // 6: reset mid-burst discards contents
        inp_valid = 1'b1;
        for (int i = 9; i < 14; i++) begin
            inp_data = 4'(i); step();
        end
        inp_valid = 1'b0;
        chk("t6_level5", level, 5);
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_ovalid", out_valid, 0);
        chk("t6_rst_odata", out_data, 0);
        chk("t6_rst_iready", inp_ready, 0);
        chk("t6_rst_afull", afull, 0);
        step();
        chk("t6_iready_back", inp_ready, 1);
        chk("t6_still_empty", out_valid, 0);
        inp_valid = 1'b1; inp_data = 4'h2;
        step();
        inp_valid = 1'b0;
        chk("t6_new_head", out_data, 4'h2);
        chk("t6_new_level", level, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
